mux_scan_ctrl: RTL and testbench
================================

Name: mux_scan_ctrl

Overview:
Sequential scan controller that sits directly upstream of the 4:1 channel mux. It drives the mux select lines, stepping through the enabled channels in order. It holds each select for a programmable dwell time, then captures the mux output for that channel. After the sweep it publishes all four captured bits as one 4-bit word with a one-cycle valid pulse, for single-shot or continuous monitoring.

Parameters:
DWELL, 4, clock cycles each enabled channel's select is held; legal range 1..255.
CW, 8, width of the dwell counter; must satisfy 2**CW > DWELL.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin one sweep; sampled only in IDLE.
continuous  input  1  1 = restart a new sweep automatically after each DONE.
enable_mask  input  4  bit i enables channel i; latched at sweep start.
mux_out  input  1  output of the downstream 4:1 mux (combinational from select0/select1).
select0  output  1  mux select LSB; channel index bit 0.
select1  output  1  mux select MSB; channel index bit 1 (channel 0=a, 1=b, 2=c, 3=d).
sample  output  4  last completed sweep; bit i = captured mux_out for channel i, 0 if disabled.
valid  output  1  one-cycle pulse: sample has just been updated.
busy  output  1  high in SCAN and DONE.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (reset). All registers update only on rising clk.
- Reset values: select0=0, select1=0, sample=4'b0000, valid=0, busy=0, state=IDLE, dwell counter=0, channel=0, shadow=0, latched mask=0.
- States: IDLE, SCAN, DONE.
- IDLE:
  - select=00, busy=0, valid=0.
  - On an edge with start=1: latch enable_mask and clear shadow.
  - If latched mask != 0: go to SCAN with channel = lowest set bit and counter = 0.
  - If mask == 0: go straight to DONE.
- SCAN:
  - {select1,select0} = channel. busy=1. Counter increments each cycle.
  - On the edge where counter == DWELL-1: shadow[channel] <= mux_out, counter <= 0, channel <= next higher enabled channel.
  - If no higher enabled channel exists: go to DONE. Disabled channels are never selected.
- DONE (exactly one cycle):
  - sample <= shadow on entry, so sample and valid change together. valid=1, busy=1, select=00.
  - Next edge: if continuous=1, re-latch enable_mask, clear shadow and start a new sweep as from IDLE (no start needed). Otherwise go to IDLE.
- Latency: with N enabled channels, SCAN is entered on the start edge and DONE on edge N*DWELL after it. valid is high for the single cycle following that edge. For N=0, DONE is entered on the start edge itself.
- Continuous mode: valid repeats every N*DWELL+1 cycles.
- Boundary conditions:
  - start while busy: ignored, no restart.
  - enable_mask changes mid-sweep: no effect until next latch.
  - continuous deasserted mid-sweep: current sweep completes, then IDLE.
  - sample holds its value between valid pulses.
  - DWELL=1: capture on the first cycle of each channel.
  - reset mid-sweep: next edge returns all outputs to reset values, partial shadow is discarded and no valid pulse is issued.
  - reset and start on the same edge: reset wins.

Test Plan:
1. Assert reset 2 cycles with start=1 -> select=00, sample=0000, valid=0, busy=0. No sweep starts after reset drops until a fresh start.
2. DWELL=4, mask=1111, mux inputs a=1, b=0, c=1, d=0, start pulsed 1 cycle -> selects 00,01,10,11 for 4 cycles each. valid high in the cycle after edge 16; sample=0101; busy drops one cycle later.
3. mask=1010, b=1, d=1, start -> only selects 01 then 11 appear, 4 cycles each. valid after edge 8; sample=1010.
4. mask=0000, start -> valid in the cycle after the start edge, sample=0000, select stays 00. Then mask=0001, a=0, start, then a=1 before the capture edge (counter=3) -> sample=0001.
5. continuous=1, mask=0011, a=1, b=1 -> valid pulses every 9 cycles with sample=0011. A start pulse mid-sweep has no effect. Dropping continuous ends the run after the current sweep.
6. Assert reset at counter=2 of channel 2 during a mask=1111 sweep -> next edge: all outputs 0, no valid pulse. A subsequent start performs a full clean sweep.

Source files
------------

// File: rtl/mux_scan_ctrl_if.sv
// Handshake bundle between the scan controller and its user plus the downstream 4:1 mux.
// The controller is the slave side; the bench or system side is the master.
interface mux_scan_ctrl_if;
    logic       start;
    logic       continuous;
    logic [3:0] enable_mask;
    logic       mux_out;
    logic       select0;
    logic       select1;
    logic [3:0] sample;
    logic       valid;
    logic       busy;

    modport master (
        output start,
        output continuous,
        output enable_mask,
        output mux_out,
        input  select0,
        input  select1,
        input  sample,
        input  valid,
        input  busy
    );

    modport slave (
        input  start,
        input  continuous,
        input  enable_mask,
        input  mux_out,
        output select0,
        output select1,
        output sample,
        output valid,
        output busy
    );
endinterface

// File: rtl/mux_scan_ctrl.sv
// Sequential scan controller for a 4:1 channel mux: dwells on each enabled channel,
// captures the mux output, and publishes the 4-bit sweep result with a one-cycle valid pulse.
module mux_scan_ctrl #(
    parameter int DWELL = 4,
    parameter int CW    = 8
) (
    input  logic               clk,
    input  logic               reset,
    mux_scan_ctrl_if.slave     bus
);

    localparam logic [1:0]    ST_IDLE    = 2'd0;
    localparam logic [1:0]    ST_SCAN    = 2'd1;
    localparam logic [1:0]    ST_DONE    = 2'd2;
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    // Returns {found, index} of the lowest set mask bit at or above start_idx.
    function automatic logic [2:0] find_chan(input logic [3:0] mask, input logic [2:0] start_idx);
        logic [2:0] res;
        res = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i >= int'(start_idx))) begin
                res = {1'b1, 2'(i)};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [1:0]    state_q,  state_d;
    logic [CW-1:0] cnt_q,    cnt_d;
    logic [1:0]    chan_q,   chan_d;
    logic [3:0]    shadow_q, shadow_d;
    logic [3:0]    mask_q,   mask_d;
    logic [3:0]    sample_q, sample_d;
    logic          valid_q,  valid_d;
    logic          busy_q,   busy_d;
    logic [1:0]    sel_q,    sel_d;

    logic          launch_s;
    logic          go_done_s;
    logic [2:0]    first_s;
    logic [2:0]    next_s;

    // Next-state logic: sweep sequencing, capture and publication.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chan_d    = chan_q;
        shadow_d  = shadow_q;
        mask_d    = mask_q;
        sample_d  = sample_q;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        sel_d     = sel_q;
        launch_s  = 1'b0;
        go_done_s = 1'b0;
        first_s   = find_chan(bus.enable_mask, 3'd0);
        next_s    = find_chan(mask_q, {1'b0, chan_q} + 3'd1);

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                sel_d  = 2'b00;
                if (bus.start) begin
                    launch_s = 1'b1;
                end else begin
                    launch_s = 1'b0;
                end
            end
            ST_SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    shadow_d[chan_q] = bus.mux_out;
                    cnt_d            = '0;
                    if (next_s[2]) begin
                        chan_d = next_s[1:0];
                        sel_d  = next_s[1:0];
                    end else begin
                        go_done_s = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DONE: begin
                if (bus.continuous) begin
                    launch_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    sel_d   = 2'b00;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                sel_d   = 2'b00;
            end
        endcase

        // A new sweep starts from a fresh mask latch and an empty shadow.
        if (launch_s) begin
            mask_d   = bus.enable_mask;
            shadow_d = 4'b0000;
            cnt_d    = '0;
            if (first_s[2]) begin
                state_d = ST_SCAN;
                chan_d  = first_s[1:0];
                sel_d   = first_s[1:0];
                busy_d  = 1'b1;
            end else begin
                go_done_s = 1'b1;
            end
        end else begin
            mask_d = mask_d;
        end

        if (go_done_s) begin
            state_d  = ST_DONE;
            sample_d = shadow_d;
            valid_d  = 1'b1;
            busy_d   = 1'b1;
            sel_d    = 2'b00;
            chan_d   = 2'b00;
        end else begin
            sample_d = sample_d;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            chan_q   <= 2'b00;
            shadow_q <= 4'b0000;
            mask_q   <= 4'b0000;
            sample_q <= 4'b0000;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            sel_q    <= 2'b00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            chan_q   <= chan_d;
            shadow_q <= shadow_d;
            mask_q   <= mask_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            busy_q   <= busy_d;
            sel_q    <= sel_d;
        end
    end

    assign bus.select0 = sel_q[0];
    assign bus.select1 = sel_q[1];
    assign bus.sample  = sample_q;
    assign bus.valid   = valid_q;
    assign bus.busy    = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl with a behavioural 4:1 mux on its select lines.
module tb_mux_scan_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] data_r;
    int         checks;
    int         failures;

    mux_scan_ctrl_if bus ();

    mux_scan_ctrl #(.DWELL(4), .CW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.mux_out = data_r[{bus.select1, bus.select0}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [3:0] exp_sample);
        check_eq({tag, "_sel"},    {6'd0, bus.select1, bus.select0}, 8'd0);
        check_eq({tag, "_valid"},  {7'd0, bus.valid}, 8'd0);
        check_eq({tag, "_busy"},   {7'd0, bus.busy}, 8'd0);
        check_eq({tag, "_sample"}, {4'd0, bus.sample}, {4'd0, exp_sample});
    endtask

    // One single-shot sweep: expected channel order is walked from the mask, 4 cycles each.
    task automatic run_sweep(input string tag, input logic [3:0] mask, input logic [3:0] exp_sample);
        bus.enable_mask = mask;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int ch = 0; ch < 4; ch++) begin
            if (mask[ch]) begin
                for (int k = 0; k < 4; k++) begin
                    check_eq({tag, "_scan_sel"},   {6'd0, bus.select1, bus.select0}, 8'(ch));
                    check_eq({tag, "_scan_busy"},  {7'd0, bus.busy}, 8'd1);
                    check_eq({tag, "_scan_valid"}, {7'd0, bus.valid}, 8'd0);
                    step();
                end
            end
        end
        check_eq({tag, "_done_valid"},  {7'd0, bus.valid}, 8'd1);
        check_eq({tag, "_done_sample"}, {4'd0, bus.sample}, {4'd0, exp_sample});
        check_eq({tag, "_done_busy"},   {7'd0, bus.busy}, 8'd1);
        check_eq({tag, "_done_sel"},    {6'd0, bus.select1, bus.select0}, 8'd0);
        step();
        check_idle({tag, "_after"}, exp_sample);
    endtask

    initial begin
        checks           = 0;
        failures         = 0;
        data_r           = 4'b0000;
        bus.start        = 1'b1;
        bus.continuous   = 1'b0;
        bus.enable_mask  = 4'b1111;
        reset            = 1'b1;

        // 1: reset dominates a held start
        step();
        step();
        check_idle("rst", 4'b0000);
        reset     = 1'b0;
        bus.start = 1'b0;
        repeat (3) step();
        check_idle("post_rst", 4'b0000);

        // 2: full mask, a=1 b=0 c=1 d=0
        data_r = 4'b0101;
        run_sweep("full", 4'b1111, 4'b0101);
        repeat (2) step();
        check_eq("hold_sample", {4'd0, bus.sample}, 8'h05);

        // 3: sparse mask 1010, b=1 d=1
        data_r = 4'b1010;
        run_sweep("sparse", 4'b1010, 4'b1010);

        // 4a: empty mask publishes zero on the cycle after start
        run_sweep("empty", 4'b0000, 4'b0000);

        // 4b: mux input changes before the capture edge
        data_r          = 4'b0000;
        bus.enable_mask = 4'b0001;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (3) step();
        data_r = 4'b0001;
        step();
        check_eq("late_valid",  {7'd0, bus.valid}, 8'd1);
        check_eq("late_sample", {4'd0, bus.sample}, 8'h01);
        step();

        // 5: continuous, period 2*4+1 = 9
        data_r          = 4'b0011;
        bus.enable_mask = 4'b0011;
        bus.continuous  = 1'b1;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check_eq("cont1_valid", {7'd0, bus.valid}, (k == 8) ? 8'd1 : 8'd0);
        end
        check_eq("cont1_sample", {4'd0, bus.sample}, 8'h03);
        for (int k = 1; k <= 9; k++) begin
            step();
            bus.start = (k == 3) ? 1'b1 : 1'b0;
            check_eq("cont2_valid", {7'd0, bus.valid}, (k == 9) ? 8'd1 : 8'd0);
            check_eq("cont2_busy",  {7'd0, bus.busy}, 8'd1);
        end
        bus.start = 1'b0;
        check_eq("cont2_sample", {4'd0, bus.sample}, 8'h03);
        for (int k = 1; k <= 9; k++) begin
            step();
            if (k == 2) bus.continuous = 1'b0;
            check_eq("cont3_valid", {7'd0, bus.valid}, (k == 9) ? 8'd1 : 8'd0);
        end
        step();
        check_idle("cont_end", 4'b0011);
        for (int k = 0; k < 10; k++) begin
            step();
            check_eq("cont_stopped", {7'd0, bus.valid | bus.busy}, 8'd0);
        end

        // 6: reset at counter 2 of channel 2
        data_r          = 4'b1111;
        bus.enable_mask = 4'b1111;
        bus.start       = 1'b1;
        step();
        bus.start = 1'b0;
        repeat (10) step();
        check_eq("pre_rst_sel", {6'd0, bus.select1, bus.select0}, 8'd2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_idle("midrst", 4'b0000);
        for (int k = 0; k < 8; k++) begin
            step();
            check_eq("midrst_quiet", {7'd0, bus.valid | bus.busy}, 8'd0);
        end
        data_r = 4'b1001;
        run_sweep("clean", 4'b1111, 4'b1001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
